// File: rtl/rom_fetch_sequencer.sv
// Walks a burst of ROM addresses, waits out the ROM read latency and hands each
// captured word to the consumer over a valid/ready handshake, pulsing done at the end.
module rom_fetch_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 128,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W:0]   cfg_count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] img_data,
  output logic              img_valid,
  input  logic              img_ready,
  output logic [ADDR_W:0]   img_index,
  output logic              img_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

  localparam logic [2:0] LAT = 3'(ROM_LAT);

  state_t            state, state_n;
  logic [ADDR_W-1:0] rom_addr_n;
  logic [ADDR_W:0]   remaining, remaining_n, img_index_n;
  logic [2:0]        lat_cnt, lat_cnt_n;
  logic [DATA_W-1:0] img_data_n;
  logic              img_valid_n, img_last_n, done_n;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= '0;
      remaining <= '0;
      img_index <= '0;
      lat_cnt   <= '0;
      img_data  <= '0;
      img_valid <= 1'b0;
      img_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      rom_addr  <= rom_addr_n;
      remaining <= remaining_n;
      img_index <= img_index_n;
      lat_cnt   <= lat_cnt_n;
      img_data  <= img_data_n;
      img_valid <= img_valid_n;
      img_last  <= img_last_n;
      done      <= done_n;
    end
  end

  // Abort overrides everything; otherwise the state decides which registers move.
  always_comb begin
    state_n     = state;
    rom_addr_n  = rom_addr;
    remaining_n = remaining;
    img_index_n = img_index;
    lat_cnt_n   = lat_cnt;
    img_data_n  = img_data;
    img_valid_n = img_valid;
    img_last_n  = img_last;
    done_n      = 1'b0;

    if (abort) begin
      state_n     = IDLE;
      img_valid_n = 1'b0;
      img_last_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_count != '0) begin
              rom_addr_n  = cfg_base;
              remaining_n = cfg_count;
              img_index_n = '0;
              lat_cnt_n   = '0;
              state_n     = FETCH;
            end else begin
              done_n = 1'b1;
            end
          end
        end
        FETCH: begin
          lat_cnt_n = lat_cnt + 3'd1;
          if (lat_cnt == LAT) begin
            img_data_n  = rom_data;
            img_valid_n = 1'b1;
            img_last_n  = (remaining == (ADDR_W+1)'(1));
            state_n     = PRESENT;
          end
        end
        PRESENT: begin
          if (img_valid && img_ready) begin
            img_valid_n = 1'b0;
            if (img_last) begin
              img_last_n = 1'b0;
              done_n     = 1'b1;
              state_n    = IDLE;
            end else begin
              rom_addr_n  = rom_addr + ADDR_W'(1);
              remaining_n = remaining - (ADDR_W+1)'(1);
              img_index_n = img_index + (ADDR_W+1)'(1);
              lat_cnt_n   = '0;
              state_n     = FETCH;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed bench for rom_fetch_sequencer with a one-stage registered ROM model;
// outputs are sampled on the falling edge, inputs driven there too.
module tb_rom_fetch_sequencer;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [7:0]   cfg_base;
  logic [8:0]   cfg_count;
  logic [7:0]   rom_addr;
  logic [127:0] rom_data;
  logic [127:0] img_data;
  logic         img_valid;
  logic         img_ready;
  logic [8:0]   img_index;
  logic         img_last;
  logic         busy;
  logic         done;

  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  rom_fetch_sequencer #(.ADDR_W(8), .DATA_W(128), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_count(cfg_count),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .img_data(img_data), .img_valid(img_valid), .img_ready(img_ready),
    .img_index(img_index), .img_last(img_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rom_word(input logic [7:0] a);
    return {8{a, ~a}};
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  always @(posedge clk) begin
    if (img_valid && img_ready) xfer_cnt <= xfer_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after start is sampled.
  task automatic applyStimulus(input logic [7:0] base, input logic [8:0] count);
    cfg_base  = base;
    cfg_count = count;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Follows a burst with img_ready held high, beginning just after the start edge.
  task automatic checkBurst(input logic [7:0] base, input int count);
    logic [7:0] a;
    for (int k = 0; k < count; k++) begin
      a = base + 8'(k);
      checkOutput("burst_addr", rom_addr, a);
      checkOutput("burst_busy", busy, 1'b1);
      checkOutput("burst_gap_valid", img_valid, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("burst_valid", img_valid, 1'b1);
      checkOutput("burst_index", img_index, 9'(k));
      checkOutput("burst_last", img_last, (k == count - 1));
      checkOutput("burst_data", img_data, rom_word(a));
      @(negedge clk);
    end
    checkOutput("burst_done", done, 1'b1);
    checkOutput("burst_done_busy", busy, 1'b0);
    checkOutput("burst_end_valid", img_valid, 1'b0);
    checkOutput("burst_end_last", img_last, 1'b0);
    @(negedge clk);
    checkOutput("burst_done_pulse", done, 1'b0);
  endtask

  initial begin
    int x0;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_base = '0; cfg_count = '0; img_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_addr", rom_addr, 8'h00);
    checkOutput("rst_valid", img_valid, 1'b0);
    checkOutput("rst_index", img_index, 9'd0);
    checkOutput("rst_last", img_last, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_data", img_data, 128'h0);

    $display("[TB] basic burst base=0x10 count=3");
    img_ready = 1'b1;
    applyStimulus(8'h10, 9'd3);
    checkBurst(8'h10, 3);

    $display("[TB] backpressure base=0x20 count=2");
    img_ready = 1'b0;
    applyStimulus(8'h20, 9'd2);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", img_valid, 1'b1);
      checkOutput("bp_data", img_data, rom_word(8'h20));
      checkOutput("bp_index", img_index, 9'd0);
      checkOutput("bp_addr", rom_addr, 8'h20);
      if (i < 4) @(negedge clk);
    end
    img_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_accept_valid", img_valid, 1'b0);
    checkOutput("bp_accept_addr", rom_addr, 8'h21);
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_w1_valid", img_valid, 1'b1);
    checkOutput("bp_w1_index", img_index, 9'd1);
    checkOutput("bp_w1_last", img_last, 1'b1);
    checkOutput("bp_w1_data", img_data, rom_word(8'h21));
    @(negedge clk);
    checkOutput("bp_done", done, 1'b1);
    @(negedge clk);

    $display("[TB] wrap base=0xFE count=4");
    x0 = xfer_cnt;
    applyStimulus(8'hFE, 9'd4);
    checkBurst(8'hFE, 4);
    checkOutput("wrap_xfers", xfer_cnt - x0, 4);

    $display("[TB] zero count");
    applyStimulus(8'h55, 9'd0);
    checkOutput("zero_done", done, 1'b1);
    checkOutput("zero_busy", busy, 1'b0);
    checkOutput("zero_addr", rom_addr, 8'h01);
    @(negedge clk);
    checkOutput("zero_done_pulse", done, 1'b0);
    checkOutput("zero_busy2", busy, 1'b0);

    $display("[TB] abort during second fetch");
    d0 = done_cnt;
    applyStimulus(8'h30, 9'd3);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ab_w0_valid", img_valid, 1'b1);
    @(negedge clk);
    checkOutput("ab_fetch_addr", rom_addr, 8'h31);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("ab_busy", busy, 1'b0);
    checkOutput("ab_valid", img_valid, 1'b0);
    checkOutput("ab_addr", rom_addr, 8'h31);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ab_idle_valid", img_valid, 1'b0);
    checkOutput("ab_no_done", done_cnt - d0, 0);
    applyStimulus(8'h40, 9'd2);
    checkBurst(8'h40, 2);

    $display("[TB] reset while presenting");
    img_ready = 1'b0;
    applyStimulus(8'h50, 9'd2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rm_valid_pre", img_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rm_addr", rom_addr, 8'h00);
    checkOutput("rm_data", img_data, 128'h0);
    checkOutput("rm_index", img_index, 9'd0);
    checkOutput("rm_valid", img_valid, 1'b0);
    checkOutput("rm_last", img_last, 1'b0);
    checkOutput("rm_done", done, 1'b0);
    checkOutput("rm_busy", busy, 1'b0);

    $display("[TB] start ignored while busy");
    img_ready = 1'b1;
    x0 = xfer_cnt;
    d0 = done_cnt;
    applyStimulus(8'h60, 9'd1);
    cfg_base = 8'h70; cfg_count = 9'd3; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("sb_valid", img_valid, 1'b1);
    checkOutput("sb_last", img_last, 1'b1);
    checkOutput("sb_data", img_data, rom_word(8'h60));
    @(negedge clk);
    checkOutput("sb_done", done, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("sb_busy", busy, 1'b0);
    checkOutput("sb_addr", rom_addr, 8'h60);
    checkOutput("sb_xfers", xfer_cnt - x0, 1);
    checkOutput("sb_dones", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_sequencer.md
# rom_fetch_sequencer

Controller that sequences image reads from the registered image ROM and hands each 128-bit image word to the perceptron datapath over a valid/ready handshake. Software or a top-level FSM programs a base address and an image count, then pulses `start`. The block walks ROM addresses, waits out the ROM read latency, holds each word stable until the consumer accepts it, and pulses `done` after the last transfer.

## Interface
- `ADDR_W`, 8, ROM address width.
- `DATA_W`, 128, ROM word width (16 bytes, byte 0 in bits [7:0]).
- `ROM_LAT`, 1, ROM read latency in clocks (registered output = 1); legal range 1–7.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset; dominates every other input.
- `start` in 1: begin a burst. Sampled only in IDLE.
- `abort` in 1: synchronous cancel, any state.
- `cfg_base` in ADDR_W: first ROM address, sampled with `start`.
- `cfg_count` in ADDR_W+1: number of images, 0..2^ADDR_W, sampled with `start`.
- `rom_addr` out ADDR_W: registered address to ROM `image_address`.
- `rom_data` in DATA_W: ROM `output_array`.
- `img_data` out DATA_W: captured image word.
- `img_valid` out 1: `img_data` is valid.
- `img_ready` in 1: consumer accepts when `img_valid & img_ready`.
- `img_index` out ADDR_W+1: position of the current word in the burst, 0..count-1.
- `img_last` out 1: current word is the final one in the burst.
- `busy` out 1: high in FETCH and PRESENT.
- `done` out 1: one-cycle pulse at burst completion.

## Operation
- States: IDLE, FETCH, PRESENT.
- **IDLE**
  - `start & !abort & cfg_count!=0`:
    - `rom_addr<=cfg_base`, `remaining<=cfg_count`, `img_index<=0`, `lat_cnt<=0`.
    - Go to FETCH.
  - `start & !abort & cfg_count==0`: `done<=1` for one cycle, stay in IDLE, no ROM access.
- **FETCH**
  - `lat_cnt` increments each cycle.
  - When `lat_cnt==ROM_LAT`:
    - `img_data<=rom_data`, `img_valid<=1`.
    - `img_last<=(remaining==1)`.
    - Go to PRESENT.
- **PRESENT**
  - `img_data`, `img_index` and `img_last` stay frozen while `img_valid & !img_ready`.
  - On handshake with `!img_last`:
    - `img_valid<=0`, `rom_addr<=rom_addr+1` (mod 2^ADDR_W, wraps 0xFF→0x00).
    - `remaining--`, `img_index++`, `lat_cnt<=0`.
    - Go to FETCH.
  - On handshake with `img_last`: `img_valid<=0`, `img_last<=0`, `done<=1`, go to IDLE.
- **abort**
  - Any state: next state IDLE, `img_valid<=0`, `img_last<=0`, `busy` low next cycle.
  - No `done` pulse; `rom_addr` and `img_data` keep their last values.
  - Abort wins over a simultaneous `start` or handshake.
- **Ignored inputs**
  - `start` is ignored while busy.
  - `cfg_*` changes during a burst have no effect.
- `busy` is a combinational decode of state != IDLE. All other outputs are registered.

## Timing
- Reset values: state IDLE; `rom_addr`, `img_data`, `img_index` = 0; `img_valid`, `img_last`, `done`, `busy` = 0.
- **First word latency**
  - Start sampled at edge E0; `rom_addr` is valid after E0.
  - The ROM registers the word at E0+ROM_LAT.
  - The block captures at E0+ROM_LAT+1; `img_valid` is high from that cycle on.
- **Word-to-word gap**
  - Handshake at edge H updates `rom_addr` at H.
  - The next `img_valid` rises after edge H+ROM_LAT+1.
  - With `img_ready` held high, throughput is 1 word per ROM_LAT+2 cycles (3 at default).
- **done**
  - Asserted for exactly the cycle after the final handshake edge.
  - `busy` drops in that same cycle.
  - A new `start` is accepted in that cycle.
- **Reset mid-burst:** all outputs return to reset values at the next edge.

## Test plan
- Reset, then `cfg_base=0x10`, `cfg_count=3`, `start`, `img_ready=1`:
  - `rom_addr` steps 0x10, 0x11, 0x12.
  - `img_valid` high at cycles 2, 5, 8 after start, with `img_index` 0, 1, 2.
  - `img_last` only on index 2; `done` at cycle 9.
- Backpressure: `img_ready=0` for 5 cycles while presenting index 0 → `img_data` and `img_index` stable and `rom_addr` unchanged; transfer completes on the first ready cycle.
- Wrap: `cfg_base=0xFE`, `cfg_count=4` → `rom_addr` sequence 0xFE, 0xFF, 0x00, 0x01; exactly 4 transfers, then `done`.
- `cfg_count=0` with `start` → `done` one cycle later; `busy` stays 0; `rom_addr` unchanged.
- `abort` during FETCH of index 1 → IDLE next cycle, `img_valid`=0, no `done`. A following `start` with count 2 completes normally.
- `rst` asserted while `img_valid=1` → all outputs 0 next cycle. `start` while busy (count 1 burst in progress) is ignored: a single transfer and a single `done`.
